flag_reg_branch_unit: RTL and testbench
=======================================

Name: flag_reg_branch_unit

Overview:
- Sits directly downstream of the 16-bit saturating add/sub in the execute stage.
- Captures its {sign, ovfl, zero} flag vector into the architectural N/V/Z flag register, using per-opcode write masks.
- Evaluates the 3-bit branch condition of a B/BR instruction in decode against those flags.
- Asserts a one-cycle hazard stall when the flags a branch needs are still in flight; optionally bypasses them instead.

Parameters:
- BYPASS, 0, 0 = stall a decode branch behind an EX flag writer; 1 = evaluate it against the forwarded next-flag value, never stall.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  pipeline stall; holds flag register and EX contents
- flush  input  1  kills the instruction currently in EX; it writes no flags
- ex_valid  input  1  EX stage holds a valid instruction
- ex_opcode  input  4  opcode of the EX instruction
- alu_flag  input  3  add/sub flags, [2]=sign(N), [1]=ovfl(V), [0]=zero(Z)
- br_valid  input  1  decode stage holds a B or BR instruction
- br_ccc  input  3  branch condition code of that instruction
- flag_q  output  3  registered architectural flags {N,V,Z}
- br_taken  output  1  branch in decode resolves taken this cycle
- flag_hazard  output  1  stall request: branch must wait one cycle for flags

Behaviour:
- Reset: rst high at a rising edge sets flag_q=3'b000. br_taken and flag_hazard are combinational and are 0 while br_valid=0.
- Reset mid-operation: rst overrides stall, flush and any pending write.
- Write masks by ex_opcode:
  - ADD 4'b0000, SUB 4'b0001: write N, V, Z.
  - XOR 4'b0010, SLL 4'b0100, SRA 4'b0101, ROR 4'b0110: write Z only.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): write nothing.
- Write enable: we = ex_valid & ~stall & ~flush & (mask != 0). Unmasked bits keep their previous value.
- Flag latency: 1 cycle; flags are visible on flag_q the cycle after the writer is in EX.
- Simultaneous stall and flush: no write occurs; flush is not deferred.
- Effective flags for branch evaluation:
  - BYPASS=0: evaluate against flag_q.
  - BYPASS=1: evaluate against the merged next value, (mask bits taken from alu_flag, the rest from flag_q), whenever we=1; otherwise against flag_q.
- Condition codes, evaluated on {N,V,Z}:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | N=0
  - 101 LTE: N=1 | Z=1
  - 110 OVFL: V=1
  - 111 UNCOND: 1
- flag_hazard (BYPASS=0 only):
  - Asserted when br_valid & ex_valid & ~flush & (mask != 0) & (br_ccc != 3'b111).
  - The stall is conservative: it ignores which flag bits are involved.
  - It lasts exactly one cycle per writer. The upstream controller converts it into a stall; the writer then retires and the next cycle evaluates against the updated flag_q.
- flag_hazard with BYPASS=1: tied to 0.
- br_taken = br_valid & ~flag_hazard & cond(effective flags, br_ccc).
- Unconditional branch (ccc=111) never stalls and is always taken when br_valid=1.
- Held state: flags persist indefinitely across non-writing instructions, stalls and flushes.
- X safety: with ex_valid=0, alu_flag and ex_opcode values are ignored.

Decomposition:
- Shared package wisc_pkg holds:
  - 4-bit opcode constants (OP_ADD ... OP_HLT).
  - 3-bit ccc constants (CC_NE ... CC_UNCOND).
  - Flag bit indices FLAG_N=2, FLAG_V=1, FLAG_Z=0.
  - A function returning the 3-bit write mask for an opcode.
- One sub-module, branch_cond_eval: purely combinational; 3-bit flags and 3-bit ccc in, 1-bit cond out. The future PC-select logic reuses it.

Test Plan:
- Reset and hold: assert rst with ex_valid=1, ADD, alu_flag=3'b111 -> flag_q=000 the next cycle; deassert rst, then 5 idle cycles -> flag_q stays 000.
- Saturating ADD then OVFL branch: EX ADD 0x7000+0x7000 (sum 0x7FFF), alu_flag=3'b010 -> flag_q=010 next cycle. Then br_ccc=110 -> br_taken=1; br_ccc=001 -> br_taken=0.
- XOR partial write: flag_q=110, then EX XOR with alu_flag=3'b001 -> flag_q=111 (N and V retained). RED with alu_flag=000 -> flag_q unchanged.
- Hazard, BYPASS=0: EX SUB with alu_flag=001 while decode holds BEQ (ccc=001) -> flag_hazard=1, br_taken=0. Next cycle (EX idle) -> flag_hazard=0, br_taken=1. Same case with ccc=111 -> no hazard, taken.
- Bypass, BYPASS=1: same SUB/BEQ case -> flag_hazard=0, br_taken=1 in the same cycle. With stall=1 -> br_taken evaluates against flag_q and flag_q is unchanged.
- Flush and stall: EX ADD with alu_flag=100 and flush=1 -> no update and no hazard. Same with stall=1, flush=0 -> no update while stall is held; update on the first cycle stall=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC constants: opcodes, branch condition codes, flag bit
// indices and the per-opcode flag write mask.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [2:0] flag_wmask(
    input logic [3:0] op
  );
    logic [2:0] m;
    m = 3'b000;
    unique case (1'b1)
      (op == OP_ADD),
      (op == OP_SUB):
        m = 3'b111;
      (op == OP_XOR),
      (op == OP_SLL),
      (op == OP_SRA),
      (op == OP_ROR):
        m[FLAG_Z] = 1'b1;
      default:
        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_reg_branch_unit_if.sv
// EX flag-writer and decode-branch bundle for the flag/branch unit.
// master = pipeline side, slave = flag_reg_branch_unit.
interface flag_reg_branch_unit_if;

  logic       stall;
  logic       flush;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic [2:0] alu_flag;
  logic       br_valid;
  logic [2:0] br_ccc;
  logic [2:0] flag_q;
  logic       br_taken;
  logic       flag_hazard;

  modport master (
    output stall, flush,
    output ex_valid, ex_opcode,
    output alu_flag,
    output br_valid, br_ccc,
    input  flag_q, br_taken,
    input  flag_hazard
  );

  modport slave (
    input  stall, flush,
    input  ex_valid, ex_opcode,
    input  alu_flag,
    input  br_valid, br_ccc,
    output flag_q, br_taken,
    output flag_hazard
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition check on {N,V,Z}.
// Ports: flags in, ccc in, cond out.
import wisc_pkg::*;

module branch_cond_eval (
  input  logic [2:0] flags,
  input  logic [2:0] ccc,
  output logic       cond
);

  logic n;
  logic v;
  logic z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  always_comb begin
    cond = 1'b0;
    unique case (ccc)
      CC_NE:     cond = ~z;
      CC_EQ:     cond = z;
      CC_GT:     cond = ~z & ~n;
      CC_LT:     cond = n;
      CC_GTE:    cond = z | ~n;
      CC_LTE:    cond = n | z;
      CC_OVFL:   cond = v;
      CC_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_reg_branch_unit.sv
// N/V/Z flag register with branch resolve and flag hazard detect.
// Ports: clk, rst (sync high), bus (slave modport of the unit bundle).
import wisc_pkg::*;

module flag_reg_branch_unit #(
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  flag_reg_branch_unit_if.slave      bus
);

  localparam bit BP = (BYPASS != 0);

  logic [2:0] flag_r;
  logic [2:0] mask;
  logic [2:0] flag_nxt;
  logic [2:0] flag_eff;
  logic       has_mask;
  logic       we;
  logic       hazard;
  logic       cond;

  // Gate with ex_valid so garbage opcodes in an empty EX are ignored.
  assign mask = bus.ex_valid ?
    flag_wmask(bus.ex_opcode) : 3'b000;
  assign has_mask = |mask;

  assign we = bus.ex_valid & ~bus.stall
            & ~bus.flush & has_mask;

  assign flag_nxt = (bus.alu_flag & mask)
                  | (flag_r & ~mask);

  always_ff @(posedge clk) begin
    if (rst)
      flag_r <= 3'b000;
    else if (we)
      flag_r <= flag_nxt;
  end

  assign flag_eff = (BP && we) ? flag_nxt : flag_r;

  // Conservative: any in-flight flag writer blocks a
  // conditional branch, whichever bits it touches.
  assign hazard = !BP && bus.br_valid
                && bus.ex_valid && !bus.flush
                && has_mask
                && (bus.br_ccc != CC_UNCOND);

  branch_cond_eval u_cond (
    .flags (flag_eff),
    .ccc   (bus.br_ccc),
    .cond  (cond)
  );

  assign bus.flag_q      = flag_r;
  assign bus.flag_hazard = hazard;
  assign bus.br_taken    = bus.br_valid
                         & ~hazard & cond;

endmodule

// File: tb/tb_flag_reg_branch_unit.sv
// Directed bench: BYPASS=0 and BYPASS=1 units driven in parallel.
// Hand-computed expectations, single checking task.
import wisc_pkg::*;

module tb_flag_reg_branch_unit;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;
  logic ex_valid;
  logic [3:0] ex_opcode;
  logic [2:0] alu_flag;
  logic br_valid;
  logic [2:0] br_ccc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_reg_branch_unit_if i0 ();
  flag_reg_branch_unit_if i1 ();

  assign i0.stall     = stall;
  assign i0.flush     = flush;
  assign i0.ex_valid  = ex_valid;
  assign i0.ex_opcode = ex_opcode;
  assign i0.alu_flag  = alu_flag;
  assign i0.br_valid  = br_valid;
  assign i0.br_ccc    = br_ccc;
  assign i1.stall     = stall;
  assign i1.flush     = flush;
  assign i1.ex_valid  = ex_valid;
  assign i1.ex_opcode = ex_opcode;
  assign i1.alu_flag  = alu_flag;
  assign i1.br_valid  = br_valid;
  assign i1.br_ccc    = br_ccc;

  flag_reg_branch_unit #(.BYPASS(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (i0)
  );

  flag_reg_branch_unit #(.BYPASS(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (i1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(
    input logic       v,
    input logic [3:0] op,
    input logic [2:0] f
  );
    ex_valid  = v;
    ex_opcode = op;
    alu_flag  = f;
  endtask

  task automatic chk_fq(
    input string      tag,
    input logic [2:0] e
  );
    chk({tag, "_fq0"}, {29'd0, i0.flag_q}, {29'd0, e});
    chk({tag, "_fq1"}, {29'd0, i1.flag_q}, {29'd0, e});
  endtask

  task automatic chk_br(
    input string tag,
    input logic  h0,
    input logic  t0,
    input logic  t1
  );
    chk({tag, "_hz0"}, {31'd0, i0.flag_hazard}, {31'd0, h0});
    chk({tag, "_tk0"}, {31'd0, i0.br_taken}, {31'd0, t0});
    chk({tag, "_hz1"}, {31'd0, i1.flag_hazard}, 32'd0);
    chk({tag, "_tk1"}, {31'd0, i1.br_taken}, {31'd0, t1});
  endtask

  task automatic set_flags(input logic [2:0] f);
    ex(1'b1, OP_ADD, f);
    step();
    ex(1'b0, OP_ADD, 3'b000);
  endtask

  // Expected cond results per ccc 0..7 for three flag values
  logic [7:0] exp_100 = 8'b1010_1001;
  logic [7:0] exp_001 = 8'b1011_0010;
  logic [7:0] exp_010 = 8'b1101_0101;
  logic [3:0] nowr [12] = '{4'h3, 4'h7, 4'h8, 4'h9,
                            4'hA, 4'hB, 4'hC, 4'hD,
                            4'hE, 4'hF, 4'h3, 4'h7};
  logic [3:0] zop  [3]  = '{OP_SLL, OP_SRA, OP_ROR};

  task automatic ccc_sweep(
    input string      tag,
    input logic [7:0] e
  );
    br_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      br_ccc = c[2:0];
      #1;
      chk_br($sformatf("%s_c%0d", tag, c),
             1'b0, e[c], e[c]);
    end
    br_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    br_valid = 1'b0;
    br_ccc = CC_UNCOND;
    ex(1'b1, OP_ADD, 3'b111);
    step();
    chk_fq("rst", 3'b000);
    chk_br("rst_nobr", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    ex(1'b0, OP_ADD, 3'b111);
    repeat (5) step();
    chk_fq("idle_hold", 3'b000);

    // saturating ADD 0x7000+0x7000 -> V only
    set_flags(3'b010);
    chk_fq("add_sat", 3'b010);
    br_valid = 1'b1;
    br_ccc = CC_OVFL;
    #1 chk_br("ovfl", 1'b0, 1'b1, 1'b1);
    br_ccc = CC_EQ;
    #1 chk_br("eq_v", 1'b0, 1'b0, 1'b0);
    br_valid = 1'b0;
    ccc_sweep("sw010", exp_010);

    // XOR writes Z only; RED writes nothing
    set_flags(3'b110);
    chk_fq("pre_xor", 3'b110);
    ex(1'b1, OP_XOR, 3'b001);
    step();
    chk_fq("xor", 3'b111);
    ex(1'b1, OP_RED, 3'b000);
    step();
    chk_fq("red", 3'b111);

    for (int k = 0; k < 3; k++) begin
      set_flags(3'b000);
      ex(1'b1, zop[k], 3'b111);
      step();
      chk_fq($sformatf("zop%0d", k), 3'b001);
    end
    ex(1'b0, OP_ADD, 3'b000);
    set_flags(3'b000);
    for (int k = 0; k < 10; k++) begin
      ex(1'b1, nowr[k], 3'b111);
      step();
    end
    chk_fq("nowrite", 3'b000);
    ex(1'b0, OP_ADD, 3'b111);
    step();
    chk_fq("xsafe", 3'b000);

    // hazard vs bypass: SUB writes Z=1 under BEQ
    ex(1'b1, OP_SUB, 3'b001);
    br_valid = 1'b1;
    br_ccc = CC_EQ;
    #1 chk_br("haz", 1'b1, 1'b0, 1'b1);
    step();
    ex(1'b0, OP_ADD, 3'b000);
    #1 chk_br("haz_after", 1'b0, 1'b1, 1'b1);
    chk_fq("sub", 3'b001);
    ex(1'b1, OP_SUB, 3'b000);
    br_ccc = CC_UNCOND;
    #1 chk_br("uncond", 1'b0, 1'b1, 1'b1);
    br_valid = 1'b0;
    ex(1'b0, OP_ADD, 3'b000);
    ccc_sweep("sw001", exp_001);

    // bypass under stall uses flag_q
    set_flags(3'b000);
    stall = 1'b1;
    ex(1'b1, OP_SUB, 3'b001);
    br_valid = 1'b1;
    br_ccc = CC_EQ;
    #1 chk_br("stall_bp", 1'b1, 1'b0, 1'b0);
    step();
    chk_fq("stall_hold", 3'b000);
    stall = 1'b0;
    br_valid = 1'b0;

    // flush: no write, no hazard
    flush = 1'b1;
    ex(1'b1, OP_ADD, 3'b100);
    br_valid = 1'b1;
    br_ccc = CC_NE;
    #1 chk_br("flush", 1'b0, 1'b1, 1'b1);
    step();
    chk_fq("flush_nw", 3'b000);
    br_valid = 1'b0;
    flush = 1'b1;
    stall = 1'b1;
    step();
    chk_fq("sf_nw", 3'b000);
    flush = 1'b0;
    repeat (2) step();
    chk_fq("stall_nw", 3'b000);
    stall = 1'b0;
    step();
    chk_fq("stall_rel", 3'b100);
    ex(1'b0, OP_ADD, 3'b000);
    ccc_sweep("sw100", exp_100);

    // reset beats stall, flush and a pending write
    rst = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    ex(1'b1, OP_ADD, 3'b111);
    step();
    chk_fq("rst_mid", 3'b000);
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    ex(1'b0, OP_ADD, 3'b000);
    step();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
